// File: rtl/mul_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mul_issue_ctrl
//
// Issue/collect stage around a fixed-latency, non-stallable registered
// multiplier. Operand pairs are accepted over valid/ready and driven straight
// to the multiplier; a tag pipeline follows each operation through the
// multiplier and the product is captured into a small result FIFO, which is
// presented downstream over valid/ready in issue order. Issue is credit
// based: an operation is only accepted when a FIFO slot is guaranteed for
// it, so nothing is ever dropped while the multiplier cannot stall.
//
// Ports
//   CLK        clock, all state updates on posedge
//   rst_n      synchronous active-low reset (also the multiplier's reset)
//   in_valid   operand pair valid
//   in_ready   credit available, operand pair can be accepted
//   in_a/in_b  multiplicand / multiplier
//   in_tag     user tag returned with the result
//   mul_a/b    operands to the multiplier (zero when not accepting)
//   mul_c      product from the multiplier
//   out_valid  result available (FIFO non-empty)
//   out_ready  downstream accepts result
//   out_c      low 32 bits of the product (zero when !out_valid)
//   out_tag    tag of out_c (zero when !out_valid)
//   busy       any op in flight or any result buffered
// ---------------------------------------------------------------------------
module mul_issue_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      mul_a,
    output logic [31:0]      mul_b,
    input  logic [31:0]      mul_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // pointer width
    localparam int FW = $clog2(DEPTH + 1);                  // fcount width
    localparam int IW = $clog2(MUL_LAT + 1);                // inflight width
    localparam int CW = $clog2(DEPTH + MUL_LAT + 1);        // credit sum width

    logic             accept;
    logic             push;
    logic             pop;

    // Tag pipeline, aligned with the multiplier's internal stages
    logic [MUL_LAT-1:0] vld_reg;
    logic [TAG_W-1:0]   tag_reg [MUL_LAT];

    // Result FIFO
    logic [31:0]      data_mem [DEPTH];
    logic [TAG_W-1:0] tmem     [DEPTH];
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [FW-1:0]    fcount_reg, fcount_next;
    logic [IW-1:0]    inflight;

    assign accept = in_valid & in_ready;
    assign push   = vld_reg[MUL_LAT-1];
    assign pop    = out_valid & out_ready;

    // Zero operands when idle keep the multiplier's inputs deterministic
    assign mul_a = accept ? in_a : 32'h0;
    assign mul_b = accept ? in_b : 32'h0;

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            vld_reg <= '0;
            for (int i = 0; i < MUL_LAT; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            vld_reg[0] <= accept;
            tag_reg[0] <= in_tag;
            for (int i = 1; i < MUL_LAT; i++) begin
                vld_reg[i] <= vld_reg[i-1];
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            inflight = inflight + IW'(vld_reg[i]);
        end
    end

    // Credit check uses registered state only: a pop this cycle frees its
    // slot for the next cycle, never combinationally.
    assign in_ready = (CW'(fcount_reg) + CW'(inflight)) < CW'(DEPTH);

    // Storage is not reset; mul_c is only sampled when the last tag stage
    // marks it valid, so an undriven product never reaches the FIFO.
    always_ff @(posedge CLK) begin
        if (rst_n && push) begin
            data_mem[wr_ptr_reg] <= mul_c;
            tmem[wr_ptr_reg]     <= tag_reg[MUL_LAT-1];
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        fcount_next = fcount_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
        end
        case ({push, pop})
            2'b10:   fcount_next = fcount_reg + FW'(1);
            2'b01:   fcount_next = fcount_reg - FW'(1);
            default: fcount_next = fcount_reg;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            fcount_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            fcount_reg <= fcount_next;
        end
    end

    assign out_valid = (fcount_reg != '0);
    assign out_c     = out_valid ? data_mem[rd_ptr_reg] : 32'h0;
    assign out_tag   = out_valid ? tmem[rd_ptr_reg] : '0;
    assign busy      = (inflight != '0) | (fcount_reg != '0);

    // Credit accounting guarantees a slot for every product; a push into a
    // full FIFO is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge CLK) disable iff (!rst_n)
        push |-> ((fcount_reg != FW'(DEPTH)) || pop));

endmodule
